// File: rtl/dlx_boot_loader.sv
// dlx_boot_loader: loads a big-endian, checksummed program image from a byte stream
// into instruction memory and holds the core in reset until the image is verified.
module dlx_boot_loader #(
    parameter int INST_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32,
    parameter logic [INST_ADDR_WIDTH-1:0] BASE_ADDR = 20'h40000,
    parameter int ADDR_INCR = 4,
    parameter int MAX_WORDS = 4096,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic                       rx_ready,
    output logic                       imem_wr_en,
    output logic [INST_ADDR_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0]      imem_wr_data,
    output logic                       core_rst_n,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [15:0]                words_loaded
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, DONE, ERROR} state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 cnt_q, cnt_d;
    logic [23:0]                shift_q, shift_d;
    logic [7:0]                 csum_q, csum_d;
    logic [TW-1:0]              tmo_q, tmo_d;
    logic [15:0]                nwords_q, nwords_d;
    logic [15:0]                wl_q, wl_d;
    logic                       wr_en_q, wr_en_d;
    logic [INST_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic                       rx_ready_q, busy_q, done_q, error_q, core_rst_n_q;
    logic [31:0]                word;
    logic                       acc, active_d;

    assign acc = rx_valid && rx_ready_q;
    assign active_d = state_d inside {HDR, DATA, CSUM};

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        shift_d = shift_q;
        csum_d = csum_q;
        tmo_d = tmo_q;
        nwords_d = nwords_q;
        wl_d = wl_q;
        wr_en_d = 1'b0;
        addr_d = addr_q;
        wdata_d = wdata_q;
        word = {shift_q, rx_data};
        if (state_q inside {IDLE, DONE, ERROR}) begin
            if (start) begin
                state_d = HDR;
                cnt_d = '0;
                csum_d = '0;
                tmo_d = '0;
                wl_d = '0;
            end
        end else if (acc) begin
            tmo_d = '0;
            shift_d = word[23:0];
            cnt_d = cnt_q + 2'd1;
            csum_d = (state_q == CSUM) ? csum_q : csum_q + rx_data;
            case (state_q)
                HDR: if (cnt_q == 2'd3) begin
                    state_d = (word > 32'(MAX_WORDS)) ? ERROR : (word == 32'd0) ? CSUM : DATA;
                    nwords_d = word[15:0];
                end
                DATA: if (cnt_q == 2'd3) begin
                    // write lands next cycle while the following byte is already accepted
                    wr_en_d = 1'b1;
                    addr_d = BASE_ADDR + INST_ADDR_WIDTH'(32'(wl_q) * 32'(ADDR_INCR));
                    wdata_d = DATA_WIDTH'(word);
                    wl_d = wl_q + 16'd1;
                    state_d = (wl_q + 16'd1 == nwords_q) ? CSUM : DATA;
                end
                default: state_d = (rx_data == csum_q) ? DONE : ERROR;
            endcase
        end else begin
            tmo_d = tmo_q + 1'b1;
            state_d = (tmo_q == TW'(TIMEOUT_CYCLES - 1)) ? ERROR : state_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            shift_q <= '0;
            csum_q <= '0;
            tmo_q <= '0;
            nwords_q <= '0;
            wl_q <= '0;
            wr_en_q <= 1'b0;
            addr_q <= BASE_ADDR;
            wdata_q <= '0;
            rx_ready_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            error_q <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            shift_q <= shift_d;
            csum_q <= csum_d;
            tmo_q <= tmo_d;
            nwords_q <= nwords_d;
            wl_q <= wl_d;
            wr_en_q <= wr_en_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            rx_ready_q <= active_d;
            busy_q <= active_d;
            done_q <= state_d == DONE;
            error_q <= state_d == ERROR;
            core_rst_n_q <= state_d == DONE;
        end
    end

    assign rx_ready = rx_ready_q;
    assign imem_wr_en = wr_en_q;
    assign imem_addr = addr_q;
    assign imem_wr_data = wdata_q;
    assign core_rst_n = core_rst_n_q;
    assign busy = busy_q;
    assign done = done_q;
    assign error = error_q;
    assign words_loaded = wl_q;
endmodule

// File: tb/tb_dlx_boot_loader.sv
// tb_dlx_boot_loader: randomized image loads checked by a scoreboard of expected
// memory writes and load outcomes derived from the image format.
module tb_dlx_boot_loader;
    localparam int MAXW = 4096;

    logic        clk = 0, rst = 1, start = 0, rx_valid = 0;
    logic [7:0]  rx_data = 0;
    logic        rx_ready, imem_wr_en, core_rst_n, busy, done, error;
    logic [19:0] imem_addr;
    logic [31:0] imem_wr_data;
    logic [15:0] words_loaded;

    typedef struct {
        bit          is_res;
        logic [19:0] addr;
        logic [31:0] data;
        logic        ok;
        logic [15:0] wl;
    } exp_t;

    exp_t        sb[$];
    exp_t        ev;
    logic [31:0] words[$];
    int          vectors = 0, miscompares = 0;
    logic        pd = 0, pe = 0;

    dlx_boot_loader #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .imem_wr_en(imem_wr_en), .imem_addr(imem_addr),
        .imem_wr_data(imem_wr_data), .core_rst_n(core_rst_n), .busy(busy), .done(done),
        .error(error), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (imem_wr_en) begin
                chk("write_expected", sb.size() != 0 && !sb[0].is_res, 1);
                if (sb.size() != 0 && !sb[0].is_res) begin
                    ev = sb.pop_front();
                    chk("wr_addr", imem_addr, ev.addr);
                    chk("wr_data", imem_wr_data, ev.data);
                end
            end
            if ((done && !pd) || (error && !pe)) begin
                chk("result_expected", sb.size() != 0 && sb[0].is_res, 1);
                if (sb.size() != 0 && sb[0].is_res) begin
                    ev = sb.pop_front();
                    chk("res_done", done, ev.ok);
                    chk("res_error", error, !ev.ok);
                    chk("res_core_rst_n", core_rst_n, ev.ok);
                    chk("res_busy", busy, 0);
                    chk("res_words", words_loaded, ev.wl);
                end
            end
        end
        pd = done;
        pe = error;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        rx_data = b;
        rx_valid = 1;
        for (int n = 0; ; n++) begin
            ok = rx_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            if (n > 50) begin
                chk("rx_ready_wait", rx_ready, 1);
                break;
            end
        end
        rx_valid = 0;
    endtask

    task automatic do_start();
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        chk("start_busy", busy, 1);
        chk("start_core_rst_n", core_rst_n, 0);
        chk("start_done", done, 0);
        chk("start_error", error, 0);
        chk("start_words", words_loaded, 0);
        chk("start_rx_ready", rx_ready, 1);
    endtask

    task automatic check_reset();
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_wr_en", imem_wr_en, 0);
        chk("rst_addr", imem_addr, 20'h40000);
        chk("rst_wdata", imem_wr_data, 0);
        chk("rst_core_rst_n", core_rst_n, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_words", words_loaded, 0);
    endtask

    task automatic load(input logic [31:0] n, input bit bad);
        logic [7:0] sum = 0;
        logic [7:0] b;
        exp_t e;
        bit fits = n <= MAXW;
        do_start();
        if (fits)
            for (int k = 0; k < int'(n); k++) begin
                e = '{0, 20'((32'h40000 + 4 * k) & 32'hfffff), words[k], 0, 0};
                sb.push_back(e);
            end
        e = '{1, 0, 0, fits && !bad, fits ? n[15:0] : 16'd0};
        sb.push_back(e);
        for (int i = 3; i >= 0; i--) begin
            if (i != 3) idle($urandom_range(0, 3));
            b = n[8*i+:8];
            sum += b;
            send_byte(b);
        end
        if (!fits) begin
            chk("oversize_rx_ready", rx_ready, 0);
            chk("oversize_error", error, 1);
            idle(4);
        end else begin
            for (int k = 0; k < int'(n); k++)
                for (int i = 3; i >= 0; i--) begin
                    idle($urandom_range(0, 3));
                    b = words[k][8*i+:8];
                    sum += b;
                    send_byte(b);
                end
            idle($urandom_range(0, 3));
            send_byte(sum + 8'(bad));
            idle(3);
        end
        chk("sb_drain", sb.size(), 0);
    endtask

    initial begin
        exp_t e;
        int n;
        idle(3);
        check_reset();
        rst = 0;
        idle(2);
        words = '{32'h20010005, 32'hFC000000};
        load(2, 0);
        load(2, 1);
        words.delete();
        load(4097, 0);
        load(0, 0);
        do_start();
        e = '{1, 0, 0, 0, 0};
        sb.push_back(e);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h20);
        n = 0;
        while (!error && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("timeout_cycles", n, 16);
        idle(2);
        chk("timeout_drain", sb.size(), 0);
        repeat (6) begin
            words.delete();
            n = $urandom_range(1, 6);
            repeat (n) words.push_back($urandom);
            load(n, $urandom_range(0, 2) == 0);
        end
        words = '{$urandom, $urandom, $urandom};
        do_start();
        e = '{0, 20'h40000, words[0], 0, 0};
        sb.push_back(e);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h03);
        for (int i = 0; i < 6; i++) send_byte(words[i/4][8*(3-i%4)+:8]);
        idle(1);
        chk("mid_drain", sb.size(), 0);
        rst = 1;
        sb.delete();
        idle(1);
        check_reset();
        rst = 0;
        idle(1);
        words = '{32'h20010005, 32'hFC000000};
        load(2, 0);
        words.delete();
        repeat (4) words.push_back($urandom);
        load(4, 0);
        idle(5);
        chk("final_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
